// File: rtl/silife_pkg.sv
// Shared definitions for the silife core access path: geometry and scheduler states.
package silife_pkg;
  localparam int ROW_W = 5;
  localparam int COLS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ_CAP,
    ST_STEP
  } sched_state_t;
endpackage

// File: rtl/silife_step_timer.sv
// Free-running step-period timer: counts 0..max(period,1)-1 while run, pulses tick at terminal count.
module silife_step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] last;

  // >= rather than == so a period shortened below the current count wraps at once.
  always_comb begin
    last = (period == '0) ? '0 : period - PERIOD_W'(1);
    tick = run && (cnt >= last);
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end
endmodule

// File: rtl/silife_access_sched.sv
// Arbitrates row writes, row reads and generation steps onto the silife core pins.
module silife_access_sched #(
  parameter int ROW_W     = silife_pkg::ROW_W,
  parameter int COLS      = silife_pkg::COLS,
  parameter int PERIOD_W  = 24,
  parameter int READ_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_run,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                step_req,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ROW_W-1:0]    wr_row,
  input  logic [COLS-1:0]     wr_data,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [ROW_W-1:0]    rd_row,
  output logic                rd_data_valid,
  output logic [COLS-1:0]     rd_data,
  input  logic                hold_display,
  output logic                step_overrun,
  output logic [ROW_W-1:0]    core_row_sel,
  output logic                core_max_en,
  output logic                core_en,
  output logic                core_wr_en,
  output logic [COLS-1:0]     core_data_in,
  input  logic [COLS-1:0]     core_data_out
);
  import silife_pkg::*;

  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_WAIT - 1);

  sched_state_t      state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              step_pending;
  logic              tick;
  logic              grant_wr, grant_rd, grant_step;

  silife_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (cfg_run),
    .period (cfg_period),
    .tick   (tick)
  );

  always_comb begin
    grant_wr   = (state == ST_IDLE) && !rst && wr_valid;
    grant_rd   = (state == ST_IDLE) && !rst && rd_valid && !wr_valid;
    grant_step = (state == ST_IDLE) && !rst && !wr_valid && !rd_valid
                 && step_pending && !hold_display;
    wr_ready   = grant_wr;
    rd_ready   = grant_rd;

    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_wr)        state_nxt = ST_WRITE;
        else if (grant_rd)   state_nxt = ST_READ_WAIT;
        else if (grant_step) state_nxt = ST_STEP;
      end
      ST_READ_WAIT: if (wait_cnt == '0) state_nxt = ST_READ_CAP;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      step_pending  <= 1'b0;
      step_overrun  <= 1'b0;
      core_row_sel  <= '0;
      core_data_in  <= '0;
      core_wr_en    <= 1'b0;
      core_en       <= 1'b0;
      core_max_en   <= 1'b1;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      core_wr_en    <= grant_wr;
      core_en       <= grant_step;
      rd_data_valid <= (state == ST_READ_WAIT) && (wait_cnt == '0);
      core_max_en   <= !(hold_display || state_nxt == ST_READ_WAIT
                         || state_nxt == ST_READ_CAP);
      // Pending drops only after the STEP cycle, so a request landing during STEP survives.
      step_pending  <= (step_pending && state != ST_STEP) || step_req || tick;
      if (tick && step_pending) step_overrun <= 1'b1;

      if (grant_wr) begin
        core_row_sel <= wr_row;
        core_data_in <= wr_data;
      end else if (grant_rd) begin
        core_row_sel <= rd_row;
        wait_cnt     <= WAIT_INIT;
      end

      if (state == ST_READ_WAIT) begin
        if (wait_cnt == '0) rd_data <= core_data_out;
        else                wait_cnt <= wait_cnt - WAIT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_silife_access_sched.sv
// Directed bench for silife_access_sched: table-driven cycle vectors plus timer/hold/reset sequences.
module tb_silife_access_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_run;
  logic [23:0] cfg_period;
  logic        step_req;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_row;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [4:0]  rd_row;
  logic        rd_data_valid;
  logic [7:0]  rd_data;
  logic        hold_display;
  logic        step_overrun;
  logic [4:0]  core_row_sel;
  logic        core_max_en, core_en, core_wr_en;
  logic [7:0]  core_data_in, core_data_out;

  int errors = 0;
  int checks = 0;

  // Core model: 32 rows of 8 cells, row 7 preloaded.
  logic [7:0] mem [32] = '{7: 8'h3C, default: 8'h00};
  always @(posedge clk) if (core_wr_en) mem[core_row_sel] <= core_data_in;
  assign core_data_out = mem[core_row_sel];

  always #5 clk = ~clk;

  silife_access_sched #(.ROW_W(5), .COLS(8), .PERIOD_W(24), .READ_WAIT(1)) dut (
    .clk(clk), .rst(rst), .cfg_run(cfg_run), .cfg_period(cfg_period),
    .step_req(step_req), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_row(rd_row), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .hold_display(hold_display), .step_overrun(step_overrun),
    .core_row_sel(core_row_sel), .core_max_en(core_max_en), .core_en(core_en),
    .core_wr_en(core_wr_en), .core_data_in(core_data_in), .core_data_out(core_data_out)
  );

  typedef struct {
    logic       wv;   logic [4:0] wrow; logic [7:0] wdata;
    logic       rv;   logic [4:0] rrow; logic sreq; logic hold;
    logic       e_wrdy; logic e_rrdy;
    logic       e_wren; logic e_en; logic e_max;
    logic [4:0] e_row;  logic [7:0] e_din; logic e_rdv; logic [7:0] e_rdata;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(logic wv, logic [4:0] wrow, logic [7:0] wdata,
                              logic rv, logic [4:0] rrow, logic sreq, logic hold,
                              logic e_wrdy, logic e_rrdy, logic e_wren, logic e_en,
                              logic e_max, logic [4:0] e_row, logic [7:0] e_din,
                              logic e_rdv, logic [7:0] e_rdata);
    vec_t v;
    v.wv = wv; v.wrow = wrow; v.wdata = wdata; v.rv = rv; v.rrow = rrow;
    v.sreq = sreq; v.hold = hold; v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy;
    v.e_wren = e_wren; v.e_en = e_en; v.e_max = e_max; v.e_row = e_row;
    v.e_din = e_din; v.e_rdv = e_rdv; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_row = '0; wr_data = '0;
    rd_valid = 0; rd_row = '0; step_req = 0; hold_display = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " wr_en"},   32'(core_wr_en),    0);
    chk({tag, " en"},      32'(core_en),       0);
    chk({tag, " max_en"},  32'(core_max_en),   1);
    chk({tag, " row_sel"}, 32'(core_row_sel),  0);
    chk({tag, " data_in"}, 32'(core_data_in),  0);
    chk({tag, " rdv"},     32'(rd_data_valid), 0);
    chk({tag, " rd_data"}, 32'(rd_data),       0);
    chk({tag, " overrun"}, 32'(step_overrun),  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse, first, last_p;
    logic gap_ok;

    //        wv wrow   wdata  rv rrow sreq hold | wrdy rrdy wren en max row  din    rdv rdata
    vt[0]  = mk(1, 5'd3,  8'hA5, 0, 5'd0, 0, 0,  1, 0, 1, 0, 1, 5'd3,  8'hA5, 0, 8'h00);
    vt[1]  = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd3,  8'hA5, 0, 8'h00);
    vt[2]  = mk(0, 5'd0,  8'h00, 1, 5'd7, 0, 0,  0, 1, 0, 0, 0, 5'd7,  8'hA5, 0, 8'h00);
    vt[3]  = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 0, 5'd7,  8'hA5, 1, 8'h3C);
    vt[4]  = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd7,  8'hA5, 0, 8'h3C);
    vt[5]  = mk(1, 5'd10, 8'h5A, 1, 5'd3, 1, 0,  1, 0, 1, 0, 1, 5'd10, 8'h5A, 0, 8'h3C);
    vt[6]  = mk(0, 5'd0,  8'h00, 1, 5'd3, 0, 0,  0, 0, 0, 0, 1, 5'd10, 8'h5A, 0, 8'h3C);
    vt[7]  = mk(0, 5'd0,  8'h00, 1, 5'd3, 0, 0,  0, 1, 0, 0, 0, 5'd3,  8'h5A, 0, 8'h3C);
    vt[8]  = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 0, 5'd3,  8'h5A, 1, 8'hA5);
    vt[9]  = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd3,  8'h5A, 0, 8'hA5);
    vt[10] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 1, 1, 5'd3,  8'h5A, 0, 8'hA5);
    vt[11] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd3,  8'h5A, 0, 8'hA5);
    vt[12] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd3,  8'h5A, 0, 8'hA5);
    vt[13] = mk(0, 5'd0,  8'h00, 1, 5'd10,0, 0,  0, 1, 0, 0, 0, 5'd10, 8'h5A, 0, 8'hA5);
    vt[14] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 0, 5'd10, 8'h5A, 1, 8'h5A);
    vt[15] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd10, 8'h5A, 0, 8'h5A);
    vt[16] = mk(0, 5'd0,  8'h00, 0, 5'd0, 1, 1,  0, 0, 0, 0, 0, 5'd10, 8'h5A, 0, 8'h5A);
    vt[17] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 1,  0, 0, 0, 0, 0, 5'd10, 8'h5A, 0, 8'h5A);
    vt[18] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 1,  0, 0, 0, 0, 0, 5'd10, 8'h5A, 0, 8'h5A);
    vt[19] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 1, 1, 5'd10, 8'h5A, 0, 8'h5A);
    vt[20] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd10, 8'h5A, 0, 8'h5A);
    vt[21] = mk(0, 5'd0,  8'h00, 0, 5'd0, 0, 0,  0, 0, 0, 0, 1, 5'd10, 8'h5A, 0, 8'h5A);

    rst = 1; cfg_run = 0; cfg_period = 24'd4;
    idle_inputs();
    repeat (3) cyc();
    chk_reset_vals("reset");
    chk("reset wr_ready", 32'(wr_ready), 0);
    rst = 0;
    cyc();

    for (int i = 0; i < 22; i++) begin
      wr_valid = vt[i].wv; wr_row = vt[i].wrow; wr_data = vt[i].wdata;
      rd_valid = vt[i].rv; rd_row = vt[i].rrow;
      step_req = vt[i].sreq; hold_display = vt[i].hold;
      #1;
      chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(vt[i].e_wrdy));
      chk($sformatf("v%0d rd_ready", i), 32'(rd_ready), 32'(vt[i].e_rrdy));
      cyc();
      chk($sformatf("v%0d wr_en", i),   32'(core_wr_en),    32'(vt[i].e_wren));
      chk($sformatf("v%0d en", i),      32'(core_en),       32'(vt[i].e_en));
      chk($sformatf("v%0d max_en", i),  32'(core_max_en),   32'(vt[i].e_max));
      chk($sformatf("v%0d row_sel", i), 32'(core_row_sel),  32'(vt[i].e_row));
      chk($sformatf("v%0d data_in", i), 32'(core_data_in),  32'(vt[i].e_din));
      chk($sformatf("v%0d rdv", i),     32'(rd_data_valid), 32'(vt[i].e_rdv));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data),       32'(vt[i].e_rdata));
    end
    idle_inputs();

    // Periodic stepping, period 4: first pulse 5 edges after enabling, then every 4.
    cfg_run = 1; cfg_period = 24'd4;
    npulse = 0; first = -1; last_p = -1; gap_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (core_en) begin
        if (first < 0) first = i;
        if (last_p >= 0 && (i - last_p) != 4) gap_ok = 1'b0;
        last_p = i;
        npulse++;
      end
    end
    chk("periodic pulse count", 32'(npulse), 9);
    chk("periodic first pulse", 32'(first), 5);
    chk("periodic spacing", 32'(gap_ok), 1);
    chk("periodic no overrun", 32'(step_overrun), 0);

    // Period 0 behaves as 1: tick every cycle, so a tick meets a pending step.
    cfg_period = 24'd0;
    cyc(); cyc();
    chk("period0 overrun", 32'(step_overrun), 1);
    cfg_run = 0; cfg_period = 24'd4;
    repeat (5) cyc();
    chk("overrun sticky", 32'(step_overrun), 1);
    chk("drained en", 32'(core_en), 0);

    // Reset asserted while a read sits in READ_WAIT.
    rd_valid = 1; rd_row = 5'd7;
    #1;
    chk("rstread rd_ready", 32'(rd_ready), 1);
    cyc();
    chk("rstread max_en low", 32'(core_max_en), 0);
    rd_valid = 0; rst = 1;
    #1;
    chk("rstread ready gated", 32'(rd_ready), 0);
    cyc();
    chk_reset_vals("rstread");
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("post-rst rdv %0d", i), 32'(rd_data_valid), 0);
      chk($sformatf("post-rst en %0d", i),  32'(core_en), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
